// File: rtl/mc_pc_unit.sv
// Program-counter register and next-PC writer for the multi-cycle CPU.
// Selects the next PC from the control strobes, traps misaligned targets to
// a fixed vector and counts taken (non-sequential) PC writes.
module mc_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        zero,
    input  logic        br_ne,
    input  logic [1:0]  pc_source,
    input  logic [31:0] seq_pc,
    input  logic [31:0] br_target,
    input  logic [25:0] jidx,
    input  logic [31:0] reg_target,
    input  logic        inst_latch,
    input  logic        exc_clear,
    output logic [31:0] pc,
    output logic [31:0] inst_pc,
    output logic [31:0] epc,
    output logic        misalign,
    output logic [15:0] taken_cnt
);

    logic [31:0] pc_q;
    logic [31:0] inst_pc_q;
    logic [31:0] epc_q;
    logic        misalign_q;
    logic [15:0] taken_cnt_q;

    logic [31:0] jump_target;
    logic [31:0] candidate;
    logic        we;
    logic        redirect;
    logic        trap;

    // Next-PC candidate selection and write/trap decode.
    always_comb begin
        // Jump region comes from the registered PC, not the next PC.
        jump_target = {pc_q[31:28], jidx, 2'b00};
        candidate   = seq_pc;
        unique case (pc_source)
            2'b00: candidate = seq_pc;
            2'b01: candidate = br_target;
            2'b10: candidate = jump_target;
            2'b11: candidate = reg_target;
            default: candidate = seq_pc;
        endcase
        // zero ^ br_ne gives beq sense when br_ne = 0 and bne sense when br_ne = 1.
        we       = pc_write | (pc_write_cond & (zero ^ br_ne));
        redirect = we & (pc_source != 2'b00);
        trap     = we & (candidate[1:0] != 2'b00);
    end

    // PC, trap and counter state; reset discards any write in the same cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc_q        <= RESET_PC;
            inst_pc_q   <= RESET_PC;
            epc_q       <= 32'h0;
            misalign_q  <= 1'b0;
            taken_cnt_q <= 16'h0;
        end else begin
            if (inst_latch) begin
                inst_pc_q <= pc_q;
            end
            if (trap) begin
                // A trap beats a simultaneous exc_clear.
                pc_q       <= EXC_VECTOR;
                epc_q      <= candidate;
                misalign_q <= 1'b1;
            end else begin
                if (exc_clear) begin
                    epc_q      <= 32'h0;
                    misalign_q <= 1'b0;
                end
                if (we) begin
                    pc_q <= candidate;
                end
                if (redirect) begin
                    taken_cnt_q <= taken_cnt_q + 16'd1;
                end
            end
        end
    end

    assign pc        = pc_q;
    assign inst_pc   = inst_pc_q;
    assign epc       = epc_q;
    assign misalign  = misalign_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_mc_pc_unit.sv
// Self-checking bench for mc_pc_unit: directed scenarios plus random cycles
// compared against a behavioural model of the PC rules.
module tb_mc_pc_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0008;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pc_write;
    logic        pc_write_cond;
    logic        zero;
    logic        br_ne;
    logic [1:0]  pc_source;
    logic [31:0] seq_pc;
    logic [31:0] br_target;
    logic [25:0] jidx;
    logic [31:0] reg_target;
    logic        inst_latch;
    logic        exc_clear;
    logic [31:0] pc;
    logic [31:0] inst_pc;
    logic [31:0] epc;
    logic        misalign;
    logic [15:0] taken_cnt;

    mc_pc_unit #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .zero          (zero),
        .br_ne         (br_ne),
        .pc_source     (pc_source),
        .seq_pc        (seq_pc),
        .br_target     (br_target),
        .jidx          (jidx),
        .reg_target    (reg_target),
        .inst_latch    (inst_latch),
        .exc_clear     (exc_clear),
        .pc            (pc),
        .inst_pc       (inst_pc),
        .epc           (epc),
        .misalign      (misalign),
        .taken_cnt     (taken_cnt)
    );

    always #5 clock = ~clock;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_inst_pc;
    logic [31:0] m_epc;
    logic        m_misalign;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        zero          = 1'b0;
        br_ne         = 1'b0;
        pc_source     = 2'b00;
        inst_latch    = 1'b0;
        exc_clear     = 1'b0;
    endtask

    // Apply current inputs for one clock, advance the model, optionally compare.
    task automatic step(input bit do_chk);
        logic [31:0] cand;
        bit          taken;
        bit          write;
        if (!resetn) begin
            m_pc       = RESET_PC;
            m_inst_pc  = RESET_PC;
            m_epc      = 32'h0;
            m_misalign = 1'b0;
            m_cnt      = 16'h0;
        end else begin
            taken = br_ne ? !zero : zero;
            write = pc_write || (pc_write_cond && taken);
            case (pc_source)
                2'd0: cand = seq_pc;
                2'd1: cand = br_target;
                2'd2: cand = {m_pc[31:28], 28'h0} + {4'h0, jidx, 2'b00};
                default: cand = reg_target;
            endcase
            if (inst_latch) m_inst_pc = m_pc;
            if (exc_clear) begin
                m_misalign = 1'b0;
                m_epc      = 32'h0;
            end
            if (write) begin
                if (cand % 4 != 0) begin
                    m_pc       = EXC_VECTOR;
                    m_epc      = cand;
                    m_misalign = 1'b1;
                end else begin
                    m_pc = cand;
                    if (pc_source != 2'd0) m_cnt = m_cnt + 16'd1;
                end
            end
        end
        @(posedge clock);
        #1;
        if (do_chk) begin
            check("pc", pc, m_pc);
            check("inst_pc", inst_pc, m_inst_pc);
            check("epc", epc, m_epc);
            check("misalign", {31'h0, misalign}, {31'h0, m_misalign});
            check("taken_cnt", {16'h0, taken_cnt}, {16'h0, m_cnt});
        end
    endtask

    // Load an aligned PC without counting a redirect.
    task automatic set_pc(input logic [31:0] v);
        idle();
        pc_write  = 1'b1;
        pc_source = 2'b00;
        seq_pc    = v;
        step(1'b1);
        idle();
    endtask

    initial begin
        logic [31:0] old_pc;
        logic [15:0] old_cnt;
        resetn     = 1'b0;
        seq_pc     = 32'h0;
        br_target  = 32'h0;
        jidx       = 26'h0;
        reg_target = 32'h0;
        idle();
        m_pc = 32'h0; m_inst_pc = 32'h0; m_epc = 32'h0; m_misalign = 1'b0; m_cnt = 16'h0;

        // Reset for two cycles, then sequential fetch.
        step(1'b1);
        step(1'b1);
        check("reset_pc", pc, RESET_PC);
        resetn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            idle();
            pc_write = 1'b1;
            seq_pc   = pc + 32'd4;
            step(1'b1);
            check("seq_pc_value", pc, 32'(4 * i));
        end
        check("seq_cnt_zero", {16'h0, taken_cnt}, 32'h0);

        // Branch, beq sense taken.
        set_pc(32'h40);
        pc_write_cond = 1'b1; pc_source = 2'b01; br_target = 32'h4C;
        zero = 1'b1; br_ne = 1'b0;
        step(1'b1);
        check("beq_taken_pc", pc, 32'h4C);
        check("beq_taken_cnt", {16'h0, taken_cnt}, 32'h1);
        // Branch, bne sense not taken.
        set_pc(32'h40);
        pc_write_cond = 1'b1; pc_source = 2'b01; br_target = 32'h4C;
        zero = 1'b1; br_ne = 1'b1;
        step(1'b1);
        check("bne_hold_pc", pc, 32'h40);
        check("bne_hold_cnt", {16'h0, taken_cnt}, 32'h1);

        // Jump keeps the upper nibble of the current PC.
        set_pc(32'hA000_0010);
        pc_write = 1'b1; pc_source = 2'b10; jidx = 26'h0000_100;
        step(1'b1);
        check("jump_pc", pc, 32'hA000_0400);

        // Misaligned jr traps without counting.
        old_cnt = taken_cnt;
        idle();
        pc_write = 1'b1; pc_source = 2'b11; reg_target = 32'h0000_1002;
        step(1'b1);
        check("trap_pc", pc, 32'h8);
        check("trap_epc", epc, 32'h1002);
        check("trap_flag", {31'h0, misalign}, 32'h1);
        check("trap_cnt", {16'h0, taken_cnt}, {16'h0, old_cnt});
        // Clear together with a new trap: the trap wins.
        exc_clear = 1'b1; reg_target = 32'h3;
        step(1'b1);
        check("trap_wins_flag", {31'h0, misalign}, 32'h1);
        check("trap_wins_epc", epc, 32'h3);
        // Clear alone.
        idle();
        exc_clear = 1'b1;
        step(1'b1);
        check("clear_flag", {31'h0, misalign}, 32'h0);
        check("clear_epc", epc, 32'h0);

        // Random cycles against the model.
        for (int i = 0; i < 400; i++) begin
            resetn        = ($urandom_range(0, 31) != 0);
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = $urandom_range(0, 1);
            zero          = $urandom_range(0, 1);
            br_ne         = $urandom_range(0, 1);
            pc_source     = 2'($urandom_range(0, 3));
            seq_pc        = $urandom;
            br_target     = $urandom;
            jidx          = 26'($urandom);
            reg_target    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                seq_pc[1:0]     = 2'b00;
                br_target[1:0]  = 2'b00;
                reg_target[1:0] = 2'b00;
            end
            inst_latch    = $urandom_range(0, 1);
            exc_clear     = ($urandom_range(0, 7) == 0);
            step(1'b1);
        end

        // Counter wrap: reset, 65535 redirects, then one more.
        resetn = 1'b0;
        idle();
        step(1'b1);
        resetn = 1'b1;
        pc_write = 1'b1; pc_source = 2'b11;
        for (int i = 0; i < 65535; i++) begin
            reg_target = 32'(i) << 2;
            step(1'b0);
        end
        check("cnt_preload", {16'h0, taken_cnt}, 32'hFFFF);
        reg_target = 32'h0000_0100;
        step(1'b1);
        check("cnt_wrap", {16'h0, taken_cnt}, 32'h0);

        // inst_latch alongside a PC write captures the old PC.
        set_pc(32'h0000_2000);
        old_pc = pc;
        pc_write = 1'b1; pc_source = 2'b00; seq_pc = 32'h0000_2004; inst_latch = 1'b1;
        step(1'b1);
        check("latch_inst_pc", inst_pc, old_pc);
        check("latch_new_pc", pc, 32'h0000_2004);

        // Reset during a write discards the write.
        idle();
        pc_write = 1'b1; pc_source = 2'b11; reg_target = 32'h2; // make misalign set first
        step(1'b1);
        resetn = 1'b0;
        pc_write = 1'b1; pc_source = 2'b00; seq_pc = 32'h100; inst_latch = 1'b1;
        step(1'b1);
        check("rst_mid_pc", pc, RESET_PC);
        check("rst_mid_inst_pc", inst_pc, RESET_PC);
        check("rst_mid_epc", epc, 32'h0);
        check("rst_mid_flag", {31'h0, misalign}, 32'h0);
        check("rst_mid_cnt", {16'h0, taken_cnt}, 32'h0);
        // First edge after reset with a write updates pc.
        resetn = 1'b1;
        idle();
        pc_write = 1'b1; seq_pc = 32'h100;
        step(1'b1);
        check("post_rst_pc", pc, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_pc_unit.md
# mc_pc_unit

Program-counter register and next-PC writer for the multi-cycle CPU; it is the consumer of the branch-target adder output (byte address = PC + offset×4). Each cycle it takes the write strobes from the multi-cycle control FSM, selects the next PC source and updates the PC register. It also traps misaligned targets to a fixed exception vector and keeps a taken-redirect counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0008, PC loaded when a misaligned target is trapped
- clock  in  1  rising-edge clock
- resetn  in  1  synchronous reset, active low
- pc_write  in  1  unconditional PC write (IF cycle, jumps)
- pc_write_cond  in  1  conditional PC write (branch execute cycle)
- zero  in  1  ALU zero flag
- br_ne  in  1  1 = bne sense (taken when zero=0); 0 = beq sense (taken when zero=1)
- pc_source  in  2  00 seq_pc, 01 br_target, 10 jump, 11 reg_target
- seq_pc  in  32  PC+4 from the ALU
- br_target  in  32  latched branch-target adder output
- jidx  in  26  jump instruction index
- reg_target  in  32  jr register value
- inst_latch  in  1  IR write strobe; captures the current PC as inst_pc
- exc_clear  in  1  clears misalign and epc
- pc  out  32  current PC
- inst_pc  out  32  address of the instruction in IR
- epc  out  32  offending misaligned target
- misalign  out  1  sticky trap flag
- taken_cnt  out  16  count of non-sequential PC writes, wraps

## Operation
- Jump target = {pc[31:28], jidx, 2'b00}. It is built from the registered pc, not next pc.
- Candidate next = mux(pc_source).
- Write enable: we = pc_write | (pc_write_cond & (zero ^ br_ne)).
- Redirect: redirect = we & (pc_source != 00).
- Trap condition: we & (candidate[1:0] != 2'b00).
  - pc <= EXC_VECTOR.
  - epc <= candidate.
  - misalign <= 1.
  - taken_cnt is not incremented.
- Normal write: we and aligned.
  - pc <= candidate.
  - taken_cnt <= taken_cnt + 1 if redirect. Mod 2^16: 16'hFFFF -> 0.
- No write (we = 0): pc holds. pc_source is then don't-care.
- inst_latch: inst_pc <= pc (the pre-update value), even when a PC write occurs in the same cycle.
- misalign is sticky.
  - exc_clear sets misalign <= 0 and epc <= 0.
  - If exc_clear and a new trap occur in the same cycle, the trap wins: misalign = 1 and epc = new target.
- A second trap while misalign = 1 overwrites epc and reloads EXC_VECTOR.
- All arithmetic is 32-bit unsigned with no overflow detection. seq_pc and targets wrap naturally.

## Timing
- All state updates on the rising edge of clock. Synchronous active-low reset has priority over every other input.
- Reset values:
  - pc = RESET_PC
  - inst_pc = RESET_PC
  - epc = 0
  - misalign = 0
  - taken_cnt = 0
- Reset mid-operation discards any write in that cycle. The first post-reset edge with we = 1 updates pc.
- Latency: one cycle. A strobe in cycle N is visible on pc in cycle N+1.
- Outputs are registered only. There is no combinational path from inputs to outputs.
- pc_write and pc_write_cond both high: treated as unconditional.
- No internal FSM state beyond misalign. Sequencing belongs to the control FSM. The block accepts a write on every cycle, including back-to-back.

## Test plan
- Reset/sequential:
  - Stimulus: RESET_PC = 0; resetn low 2 cycles; then pc_write = 1, pc_source = 00, seq_pc = pc + 4 for 3 cycles.
  - Required: pc = 0 -> 4 -> 8 -> 12; taken_cnt = 0.
- Branch sense:
  - Stimulus: pc = 0x40, br_target = 0x40 + 3×4 = 0x4C, pc_write_cond = 1, pc_source = 01.
  - zero = 1, br_ne = 0: pc = 0x4C, taken_cnt = 1.
  - zero = 1, br_ne = 1: pc stays 0x40, count unchanged.
- Jump:
  - Stimulus: pc = 0xA000_0010, jidx = 26'h0000_100, pc_source = 10, pc_write = 1.
  - Required: pc = 0xA000_0400.
- Misaligned jr:
  - Stimulus: reg_target = 0x0000_1002, pc_source = 11, pc_write = 1.
  - Required: pc = 0x8, epc = 0x1002, misalign = 1, taken_cnt unchanged.
  - Then exc_clear = 1 together with a new misaligned target 0x3: misalign stays 1, epc = 0x3.
- Counter wrap / inst_latch:
  - Preload taken_cnt to 0xFFFF through 65535 redirects, then one more redirect: taken_cnt = 0.
  - inst_latch with pc_write in the same cycle: inst_pc = old pc, pc = new value.
- Reset mid-write:
  - Stimulus: resetn = 0 with pc_write = 1, seq_pc = 0x100.
  - Required: pc = RESET_PC and all other outputs at their reset values.
